// File: rtl/morse_seq_game_ctrl.sv
// Morse memory game controller: shows a sequence of SEQ_LEN Morse digits,
// collects the player's entries, compares them in order and keeps a
// saturating BCD score and a lives counter. All outputs are registered.
module morse_seq_game_ctrl #(
    parameter int SEQ_LEN      = 2,
    parameter int DIGIT_W      = 4,
    parameter int SCORE_DIGITS = 2,
    parameter int LIVES        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      LoggedIn,
    input  logic                      game_start,
    input  logic                      logout,
    input  logic [DIGIT_W-1:0]        morse_number,
    input  logic                      show_done,
    input  logic                      timeout,
    input  logic                      load,
    input  logic [DIGIT_W-1:0]        user_input,
    output logic                      reconfig,
    output logic                      enable,
    output logic                      enable_show,
    output logic [DIGIT_W-1:0]        number,
    output logic [2:0]                digit_idx,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [3:0]                lives_left,
    output logic                      correct,
    output logic                      wrong,
    output logic                      logout_from_gamecontrol
);

    localparam int SCORE_W = 4 * SCORE_DIGITS;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RECONFIG   = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_SHOW       = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;
    localparam logic [2:0] ST_ENTRY      = 3'd5;
    localparam logic [2:0] ST_DECISION   = 3'd6;
    localparam logic [2:0] ST_GAMEOVER   = 3'd7;

    localparam logic [2:0] LAST_IDX   = 3'(SEQ_LEN - 1);
    localparam logic [3:0] LIVES_INIT = 4'(LIVES);

    logic [2:0]         state;
    logic               err_flag;
    // Sized for the largest legal sequence so the 3-bit index always fits.
    logic [DIGIT_W-1:0] seq_buf [8];

    // BCD increment with per-digit carry; an all-9s score stays put.
    function automatic logic [SCORE_W-1:0] bcd_sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        logic               all_nine;
        r        = v;
        carry    = 1'b1;
        all_nine = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) all_nine = 1'b0;
        end
        if (!all_nine) begin
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Game FSM with registered outputs: logout beats timeout beats normal flow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                   <= ST_IDLE;
            err_flag                <= 1'b0;
            reconfig                <= 1'b0;
            enable                  <= 1'b0;
            enable_show             <= 1'b0;
            number                  <= '0;
            digit_idx               <= 3'd0;
            score                   <= '0;
            lives_left              <= 4'd0;
            correct                 <= 1'b0;
            wrong                   <= 1'b0;
            logout_from_gamecontrol <= 1'b0;
            for (int i = 0; i < 8; i++) seq_buf[i] <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            reconfig                <= 1'b0;
            correct                 <= 1'b0;
            wrong                   <= 1'b0;
            logout_from_gamecontrol <= 1'b0;

            if (logout && (state != ST_IDLE)) begin
                logout_from_gamecontrol <= 1'b1;
                state       <= ST_IDLE;
                err_flag    <= 1'b0;
                enable      <= 1'b0;
                enable_show <= 1'b0;
                number      <= '0;
                digit_idx   <= 3'd0;
                score       <= '0;
                lives_left  <= 4'd0;
                for (int i = 0; i < 8; i++) seq_buf[i] <= '0;
            end else if (timeout && ((state == ST_SHOW) || (state == ST_GAP) ||
                                     (state == ST_ENTRY) || (state == ST_DECISION))) begin
                // The round in flight is discarded; score and lives stay as they were.
                state       <= ST_GAMEOVER;
                err_flag    <= 1'b0;
                enable      <= 1'b0;
                enable_show <= 1'b0;
                number      <= '0;
                digit_idx   <= 3'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (LoggedIn) begin
                            state      <= ST_RECONFIG;
                            reconfig   <= 1'b1;
                            score      <= '0;
                            lives_left <= LIVES_INIT;
                            enable     <= 1'b0;
                        end
                    end
                    ST_RECONFIG: begin
                        state <= ST_WAIT_START;
                    end
                    ST_WAIT_START: begin
                        if (game_start) begin
                            state       <= ST_SHOW;
                            enable      <= 1'b1;
                            enable_show <= 1'b1;
                            number      <= morse_number;
                            digit_idx   <= 3'd0;
                            err_flag    <= 1'b0;
                        end
                    end
                    ST_SHOW: begin
                        if (show_done) begin
                            seq_buf[digit_idx] <= morse_number;
                            enable_show        <= 1'b0;
                            number             <= '0;
                            if (digit_idx == LAST_IDX) begin
                                state     <= ST_ENTRY;
                                digit_idx <= 3'd0;
                            end else begin
                                state     <= ST_GAP;
                                digit_idx <= digit_idx + 3'd1;
                            end
                        end else begin
                            enable_show <= 1'b1;
                            number      <= morse_number;
                        end
                    end
                    ST_GAP: begin
                        // One idle cycle with enable_show low restarts the show timer.
                        state       <= ST_SHOW;
                        enable_show <= 1'b1;
                        number      <= morse_number;
                    end
                    ST_ENTRY: begin
                        if (load) begin
                            if (user_input != seq_buf[digit_idx]) err_flag <= 1'b1;
                            if (digit_idx == LAST_IDX) begin
                                state <= ST_DECISION;
                            end else begin
                                digit_idx <= digit_idx + 3'd1;
                            end
                        end
                    end
                    ST_DECISION: begin
                        digit_idx <= 3'd0;
                        err_flag  <= 1'b0;
                        if (!err_flag) begin
                            score       <= bcd_sat_inc(score);
                            correct     <= 1'b1;
                            state       <= ST_SHOW;
                            enable_show <= 1'b1;
                            number      <= morse_number;
                        end else begin
                            wrong      <= 1'b1;
                            lives_left <= lives_left - 4'd1;
                            if (lives_left == 4'd1) begin
                                state       <= ST_GAMEOVER;
                                enable      <= 1'b0;
                                enable_show <= 1'b0;
                                number      <= '0;
                            end else begin
                                state       <= ST_SHOW;
                                enable_show <= 1'b1;
                                number      <= morse_number;
                            end
                        end
                    end
                    ST_GAMEOVER: begin
                        // Score and lives stay visible until the next start request.
                        if (game_start) begin
                            state      <= ST_RECONFIG;
                            reconfig   <= 1'b1;
                            score      <= '0;
                            lives_left <= LIVES_INIT;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_seq_game_ctrl.sv
// Directed bench for morse_seq_game_ctrl: a SEQ_LEN=2 instance and a
// SEQ_LEN=4 instance driven from the same inputs, checked against
// hand-computed values.
module tb_morse_seq_game_ctrl;

    logic       clk;
    logic       rst;
    logic       logged_in;
    logic       game_start;
    logic       logout;
    logic [3:0] morse_number;
    logic       show_done;
    logic       timeout;
    logic       load;
    logic [3:0] user_input;

    logic       a_reconfig, a_enable, a_es, a_correct, a_wrong, a_ack;
    logic [3:0] a_number, a_lives;
    logic [2:0] a_idx;
    logic [7:0] a_score;

    logic       b_reconfig, b_enable, b_es, b_correct, b_wrong, b_ack;
    logic [3:0] b_number, b_lives;
    logic [2:0] b_idx;
    logic [7:0] b_score;

    int n_checks;
    int n_errors;

    morse_seq_game_ctrl dut_a (
        .clk(clk), .rst(rst), .LoggedIn(logged_in), .game_start(game_start),
        .logout(logout), .morse_number(morse_number), .show_done(show_done),
        .timeout(timeout), .load(load), .user_input(user_input),
        .reconfig(a_reconfig), .enable(a_enable), .enable_show(a_es),
        .number(a_number), .digit_idx(a_idx), .score(a_score),
        .lives_left(a_lives), .correct(a_correct), .wrong(a_wrong),
        .logout_from_gamecontrol(a_ack)
    );

    morse_seq_game_ctrl #(.SEQ_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .LoggedIn(logged_in), .game_start(game_start),
        .logout(logout), .morse_number(morse_number), .show_done(show_done),
        .timeout(timeout), .load(load), .user_input(user_input),
        .reconfig(b_reconfig), .enable(b_enable), .enable_show(b_es),
        .number(b_number), .digit_idx(b_idx), .score(b_score),
        .lives_left(b_lives), .correct(b_correct), .wrong(b_wrong),
        .logout_from_gamecontrol(b_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] d);
        morse_number = d;
        tick();
        show_done = 1'b1;
        tick();
        show_done = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d);
        user_input = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // One SEQ_LEN=2 round starting in SHOW, ending just after the DECISION edge.
    task automatic play(input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] e0, input logic [3:0] e1);
        show(s0);
        show(s1);
        enter(e0);
        enter(e1);
        tick();
    endtask

    initial begin
        logic [3:0] seq_b [4];
        logic [3:0] ent_b [4];
        int gaps;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0; logged_in = 1'b0; game_start = 1'b0; logout = 1'b0;
        morse_number = 4'd0; show_done = 1'b0; timeout = 1'b0; load = 1'b0;
        user_input = 4'd0;
        tick();
        tick();

        // Reset state
        chk("rst_reconfig", 32'(a_reconfig), 32'd0);
        chk("rst_enable",   32'(a_enable),   32'd0);
        chk("rst_es",       32'(a_es),       32'd0);
        chk("rst_number",   32'(a_number),   32'd0);
        chk("rst_idx",      32'(a_idx),      32'd0);
        chk("rst_score",    32'(a_score),    32'd0);
        chk("rst_lives",    32'(a_lives),    32'd0);
        chk("rst_pulses",   32'({a_correct, a_wrong, a_ack}), 32'd0);

        rst = 1'b1;
        tick();
        chk("idle_no_login", 32'(a_reconfig), 32'd0);

        // Login and start
        logged_in = 1'b1;
        tick();
        chk("login_reconfig", 32'(a_reconfig), 32'd1);
        chk("login_lives",    32'(a_lives),    32'd3);
        chk("login_score",    32'(a_score),    32'd0);
        tick();
        chk("reconfig_one_cycle", 32'(a_reconfig), 32'd0);
        chk("wait_enable",        32'(a_enable),   32'd0);
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("start_enable", 32'(a_enable), 32'd1);
        chk("start_es",     32'(a_es),     32'd1);
        chk("start_idx",    32'(a_idx),    32'd0);

        // Correct round: show 5, 9; enter 5, 9
        morse_number = 4'd5;
        tick();
        chk("show0_number", 32'(a_number), 32'd5);
        show_done = 1'b1;
        tick();
        show_done = 1'b0;
        chk("gap_es",     32'(a_es),     32'd0);
        chk("gap_idx",    32'(a_idx),    32'd1);
        chk("gap_number", 32'(a_number), 32'd0);
        morse_number = 4'd9;
        tick();
        chk("show1_number", 32'(a_number), 32'd9);
        chk("show1_es",     32'(a_es),     32'd1);
        show_done = 1'b1;
        tick();
        show_done = 1'b0;
        chk("entry_idx", 32'(a_idx), 32'd0);
        chk("entry_es",  32'(a_es),  32'd0);
        enter(4'd5);
        chk("entry_idx1", 32'(a_idx), 32'd1);
        enter(4'd9);
        chk("decision_no_pulse", 32'(a_correct), 32'd0);
        tick();
        chk("r1_correct", 32'(a_correct), 32'd1);
        chk("r1_wrong",   32'(a_wrong),   32'd0);
        chk("r1_score",   32'(a_score),   32'h01);
        chk("r1_lives",   32'(a_lives),   32'd3);
        chk("r1_es",      32'(a_es),      32'd1);
        chk("r1_idx",     32'(a_idx),     32'd0);
        tick();
        chk("r1_correct_one_cycle", 32'(a_correct), 32'd0);

        // Wrong rounds down to game over
        play(4'd3, 4'd4, 4'd7, 4'd4);
        chk("w1_wrong",   32'(a_wrong),   32'd1);
        chk("w1_correct", 32'(a_correct), 32'd0);
        chk("w1_lives",   32'(a_lives),   32'd2);
        chk("w1_score",   32'(a_score),   32'h01);
        play(4'd3, 4'd4, 4'd3, 4'd8);
        chk("w2_lives", 32'(a_lives), 32'd1);
        play(4'd1, 4'd2, 4'd0, 4'd0);
        chk("w3_wrong",  32'(a_wrong),  32'd1);
        chk("w3_lives",  32'(a_lives),  32'd0);
        chk("go_enable", 32'(a_enable), 32'd0);
        chk("go_es",     32'(a_es),     32'd0);
        chk("go_number", 32'(a_number), 32'd0);
        chk("go_score",  32'(a_score),  32'h01);
        tick();
        chk("go_wrong_one_cycle", 32'(a_wrong), 32'd0);
        chk("go_score_held",      32'(a_score), 32'h01);

        // Restart from game over
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("restart_reconfig", 32'(a_reconfig), 32'd1);
        chk("restart_score",    32'(a_score),    32'd0);
        chk("restart_lives",    32'(a_lives),    32'd3);
        tick();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;

        // BCD carry and saturation
        for (int i = 0; i < 9; i++) play(4'd1, 4'd2, 4'd1, 4'd2);
        chk("bcd_09", 32'(a_score), 32'h09);
        play(4'd6, 4'd7, 4'd6, 4'd7);
        chk("bcd_10",         32'(a_score),   32'h10);
        chk("bcd_10_correct", 32'(a_correct), 32'd1);
        for (int i = 0; i < 89; i++) play(4'd2, 4'd8, 4'd2, 4'd8);
        chk("bcd_99", 32'(a_score), 32'h99);
        play(4'd4, 4'd4, 4'd4, 4'd4);
        chk("bcd_sat",         32'(a_score),   32'h99);
        chk("bcd_sat_correct", 32'(a_correct), 32'd1);

        // Timeout together with the last load
        show(4'd1);
        show(4'd2);
        enter(4'd1);
        user_input = 4'd2;
        load = 1'b1;
        timeout = 1'b1;
        tick();
        load = 1'b0;
        timeout = 1'b0;
        chk("to_enable", 32'(a_enable), 32'd0);
        chk("to_pulses", 32'({a_correct, a_wrong}), 32'd0);
        chk("to_score",  32'(a_score),  32'h99);
        chk("to_lives",  32'(a_lives),  32'd3);
        tick();
        chk("to_pulses_after", 32'({a_correct, a_wrong}), 32'd0);
        chk("to_score_held",   32'(a_score), 32'h99);
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("to_restart_reconfig", 32'(a_reconfig), 32'd1);
        chk("to_restart_score",    32'(a_score),    32'd0);
        tick();
        chk("to_reconfig_low", 32'(a_reconfig), 32'd0);

        // Logout mid-SHOW
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        morse_number = 4'd6;
        tick();
        chk("pre_logout_number", 32'(a_number), 32'd6);
        logout = 1'b1;
        logged_in = 1'b0;
        tick();
        logout = 1'b0;
        chk("logout_ack",    32'(a_ack),    32'd1);
        chk("logout_enable", 32'(a_enable), 32'd0);
        chk("logout_es",     32'(a_es),     32'd0);
        chk("logout_number", 32'(a_number), 32'd0);
        chk("logout_lives",  32'(a_lives),  32'd0);
        tick();
        chk("logout_ack_one_cycle", 32'(a_ack),      32'd0);
        chk("idle_reconfig",        32'(a_reconfig), 32'd0);

        // Reset mid-ENTRY
        logged_in = 1'b1;
        tick();
        tick();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        show(4'd3);
        show(4'd4);
        enter(4'd3);
        chk("pre_rst_enable", 32'(a_enable), 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_rst_enable", 32'(a_enable), 32'd0);
        chk("mid_rst_lives",  32'(a_lives),  32'd0);
        chk("mid_rst_idx",    32'(a_idx),    32'd0);
        chk("mid_rst_pulses", 32'({a_reconfig, a_correct, a_wrong, a_ack}), 32'd0);

        // Longer sequence on the SEQ_LEN=4 instance
        rst = 1'b1;
        tick();
        chk("b_reconfig", 32'(b_reconfig), 32'd1);
        chk("b_lives",    32'(b_lives),    32'd3);
        tick();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("b_enable", 32'(b_enable), 32'd1);
        seq_b = '{4'd1, 4'd2, 4'd3, 4'd4};
        ent_b = '{4'd1, 4'd2, 4'd3, 4'd4};
        gaps = 0;
        for (int i = 0; i < 4; i++) begin
            morse_number = seq_b[i];
            tick();
            chk("b_show_number", 32'(b_number), 32'(seq_b[i]));
            chk("b_show_es",     32'(b_es),     32'd1);
            show_done = 1'b1;
            tick();
            show_done = 1'b0;
            if (i < 3 && b_es == 1'b0 && b_idx == 3'(i + 1) && b_number == 4'd0) gaps++;
        end
        chk("b_gap_count", 32'(gaps),  32'd3);
        chk("b_entry_idx", 32'(b_idx), 32'd0);
        for (int i = 0; i < 4; i++) enter(ent_b[i]);
        tick();
        chk("b_correct", 32'(b_correct), 32'd1);
        chk("b_score",   32'(b_score),   32'h01);
        ent_b[3] = 4'd5;
        for (int i = 0; i < 4; i++) show(seq_b[i]);
        for (int i = 0; i < 4; i++) enter(ent_b[i]);
        tick();
        chk("b_wrong",       32'(b_wrong),   32'd1);
        chk("b_wrong_nocor", 32'(b_correct), 32'd0);
        chk("b_wrong_lives", 32'(b_lives),   32'd2);
        chk("b_wrong_score", 32'(b_score),   32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
